// File: rtl/udp_report_tx.sv
// udp_report_tx: serialises 32-bit order-book words into UDP payload frames.
// Each frame is a 3-byte opcode followed by big-endian words; tlast marks the
// final byte. A frame closes on a tlast word, on the dump sentinel, or when it
// reaches MAX_WORDS words. Header bytes are added downstream by the UDP TX core.
module udp_report_tx #(
    parameter logic [23:0] OP_DUMP_RSP  = 24'hF0E0D0,
    parameter logic [23:0] OP_TRADE_RPT = 24'hFED001,
    parameter int          MAX_WORDS    = 64,
    parameter logic [31:0] SENTINEL     = 32'hFFFF_FFFF
) (
    input  logic        clk_udp,
    input  logic        rst_udp,
    input  logic [31:0] s_word_tdata,
    input  logic        s_word_tvalid,
    input  logic        s_word_tlast,
    input  logic        s_word_is_dump,
    output logic        s_word_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        o_busy,
    output logic [15:0] o_frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPC,
        ST_WORD,
        ST_FETCH
    } state_t;

    localparam logic [8:0] MAX_W9 = 9'(MAX_WORDS);

    state_t      state;
    logic [1:0]  byte_idx;
    logic [31:0] word_q;
    logic        dump_q;
    logic [7:0]  wcnt;
    logic        end_q;

    logic        word_hs;
    logic        byte_hs;
    logic [8:0]  wcnt_next;

    // Opcode byte idx (0 = most significant) for the selected frame type.
    function automatic logic [7:0] opc_byte(input logic is_dump, input logic [1:0] idx);
        logic [23:0] opc;
        opc = is_dump ? OP_DUMP_RSP : OP_TRADE_RPT;
        case (idx)
            2'd0:    return opc[23:16];
            2'd1:    return opc[15:8];
            default: return opc[7:0];
        endcase
    endfunction

    // Word byte idx in big-endian order (0 = bits [31:24]).
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    // NOTE: tready is the only combinational output; it is gated by rst_udp so
    // the source never sees an accept while the FSM is being forced to IDLE.
    assign s_word_tready = !rst_udp && ((state == ST_IDLE) || (state == ST_FETCH));
    assign word_hs       = s_word_tvalid & s_word_tready;
    assign byte_hs       = m_axis_tvalid & m_axis_tready;
    assign wcnt_next     = {1'b0, wcnt} + 9'd1;

    // Framing FSM with registered AXI-stream outputs and frame statistics.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_udp) begin
        if (rst_udp) begin
            state         <= ST_IDLE;
            byte_idx      <= 2'd0;
            word_q        <= 32'd0;
            dump_q        <= 1'b0;
            wcnt          <= 8'd0;
            end_q         <= 1'b0;
            m_axis_tdata  <= 8'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            o_busy        <= 1'b0;
            o_frame_count <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (word_hs) begin
                        word_q        <= s_word_tdata;
                        dump_q        <= s_word_is_dump;
                        wcnt          <= 8'd1;
                        end_q         <= s_word_tlast
                                       | (s_word_is_dump & (s_word_tdata == SENTINEL))
                                       | (MAX_WORDS == 1);
                        byte_idx      <= 2'd0;
                        m_axis_tdata  <= opc_byte(s_word_is_dump, 2'd0);
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        o_busy        <= 1'b1;
                        state         <= ST_OPC;
                    end
                end

                ST_OPC: begin
                    if (byte_hs) begin
                        if (byte_idx == 2'd2) begin
                            byte_idx     <= 2'd0;
                            m_axis_tdata <= word_byte(word_q, 2'd0);
                            state        <= ST_WORD;
                        end else begin
                            byte_idx     <= byte_idx + 2'd1;
                            m_axis_tdata <= opc_byte(dump_q, byte_idx + 2'd1);
                        end
                    end
                end

                ST_WORD: begin
                    if (byte_hs) begin
                        if (byte_idx == 2'd3) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            if (end_q) begin
                                o_frame_count <= o_frame_count + 16'd1;
                                o_busy        <= 1'b0;
                                state         <= ST_IDLE;
                            end else begin
                                state <= ST_FETCH;
                            end
                        end else begin
                            byte_idx     <= byte_idx + 2'd1;
                            m_axis_tdata <= word_byte(word_q, byte_idx + 2'd1);
                            m_axis_tlast <= end_q && (byte_idx == 2'd2);
                        end
                    end
                end

                ST_FETCH: begin
                    // The opcode chosen at frame start stays; is_dump is ignored here.
                    if (word_hs) begin
                        word_q        <= s_word_tdata;
                        wcnt          <= wcnt + 8'd1;
                        end_q         <= s_word_tlast
                                       | (dump_q & (s_word_tdata == SENTINEL))
                                       | (wcnt_next == MAX_W9);
                        byte_idx      <= 2'd0;
                        m_axis_tdata  <= word_byte(s_word_tdata, 2'd0);
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        state         <= ST_WORD;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_report_tx.sv
// Bench for udp_report_tx: a frame-level model turns each sent word into the
// bytes it must produce; a compare process checks every accepted byte and the
// hold rule during stalls, and scenarios pin timing and literal byte streams.
module tb_udp_report_tx;

    localparam int MAXW = 4;

    logic        clk_udp = 1'b0;
    logic        rst_udp = 1'b1;
    logic [31:0] s_word_tdata = 32'd0;
    logic        s_word_tvalid = 1'b0;
    logic        s_word_tlast = 1'b0;
    logic        s_word_is_dump = 1'b0;
    logic        s_word_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic        o_busy;
    logic [15:0] o_frame_count;

    udp_report_tx #(.MAX_WORDS(MAXW)) dut (
        .clk_udp        (clk_udp),
        .rst_udp        (rst_udp),
        .s_word_tdata   (s_word_tdata),
        .s_word_tvalid  (s_word_tvalid),
        .s_word_tlast   (s_word_tlast),
        .s_word_is_dump (s_word_is_dump),
        .s_word_tready  (s_word_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .o_busy         (o_busy),
        .o_frame_count  (o_frame_count)
    );

    initial forever #4 clk_udp = ~clk_udp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = 0;
    bit bp_en = 1'b0;

    always @(posedge clk_udp) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic [8:0] exp_q[$];
    bit         m_in_frame = 1'b0;
    bit         m_dump = 1'b0;
    int         m_cnt = 0;
    int         m_frames = 0;

    function automatic void model_push(input logic [31:0] d, input logic last, input logic dump);
        logic [23:0] opc;
        bit          fin;
        if (!m_in_frame) begin
            m_in_frame = 1'b1;
            m_dump     = dump;
            m_cnt      = 0;
            opc        = dump ? 24'hF0E0D0 : 24'hFED001;
            for (int i = 2; i >= 0; i--) exp_q.push_back({1'b0, opc[8*i +: 8]});
        end
        m_cnt++;
        fin = last || (m_dump && d == 32'hFFFF_FFFF) || (m_cnt == MAXW);
        for (int i = 3; i >= 0; i--) exp_q.push_back({(fin && (i == 0)), d[8*i +: 8]});
        if (fin) begin
            m_in_frame = 1'b0;
            m_frames   = (m_frames + 1) & 16'hFFFF;
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_in_frame = 1'b0;
        m_cnt      = 0;
        m_frames   = 0;
    endfunction

    // ---------------- compare process ----------------
    logic [8:0] got_q[$];
    int         got_cyc[$];
    bit         prev_stall = 1'b0;
    logic [8:0] prev_beat = 9'd0;

    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk_udp);
            if (rst_udp) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(m_axis_tvalid), 32'd1);
                    check("stall_hold", 32'({m_axis_tlast, m_axis_tdata}), 32'(prev_beat));
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    got_q.push_back({m_axis_tlast, m_axis_tdata});
                    got_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_byte: got %h expected none", {m_axis_tlast, m_axis_tdata});
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", 32'({m_axis_tlast, m_axis_tdata}), 32'(e));
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_beat  = {m_axis_tlast, m_axis_tdata};
            end
        end
    end

    // Downstream ready: constant 1, or pseudo-random when backpressure is on.
    initial forever begin
        @(posedge clk_udp);
        #1;
        m_axis_tready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_word(input logic [31:0] d, input logic last, input logic dump);
        int t = 0;
        s_word_tdata   = d;
        s_word_tlast   = last;
        s_word_is_dump = dump;
        s_word_tvalid  = 1'b1;
        forever begin
            @(negedge clk_udp);
            if (s_word_tready) break;
            t++;
            if (t > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: word %h never accepted", d);
                break;
            end
        end
        hs_cyc = cyc;
        model_push(d, last, dump);
        @(posedge clk_udp);
        #1;
        s_word_tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        forever begin
            @(negedge clk_udp);
            if (exp_q.size() == 0 && !o_busy && !m_axis_tvalid) break;
            t++;
            if (t > 2000) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: %0d bytes outstanding, busy %0d", exp_q.size(), o_busy);
                break;
            end
        end
    endtask

    task automatic clear_log();
        got_q.delete();
        got_cyc.delete();
    endtask

    // ---------------- scenarios ----------------
    logic [8:0] lit1 [7];
    logic [8:0] lit2 [15];

    initial begin
        lit1 = '{9'h0FE, 9'h0D0, 9'h001, 9'h000, 9'h05A, 9'h080, 9'h114};
        lit2 = '{9'h0F0, 9'h0E0, 9'h0D0, 9'h000, 9'h069, 9'h000, 9'h00A,
                 9'h000, 9'h05A, 9'h080, 9'h014, 9'h0FF, 9'h0FF, 9'h0FF, 9'h1FF};

        // Reset values.
        repeat (3) @(negedge clk_udp);
        check("rst_tready", 32'(s_word_tready), 32'd0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_count", 32'(o_frame_count), 32'd0);
        @(posedge clk_udp);
        #1 rst_udp = 1'b0;
        @(negedge clk_udp);
        check("post_rst_tready", 32'(s_word_tready), 32'd1);

        // 1: single trade report, latency pinned.
        @(posedge clk_udp);
        #1 clear_log();
        send_word(32'h005A_8014, 1'b1, 1'b0);
        do @(negedge clk_udp); while (cyc < hs_cyc + 8);
        check("s1_len", 32'(got_q.size()), 32'd7);
        for (int i = 0; i < 7; i++) check("s1_lit", 32'(got_q[i]), 32'(lit1[i]));
        check("s1_first_lat", 32'(got_cyc[0] - hs_cyc), 32'd1);
        check("s1_last_lat", 32'(got_cyc[6] - hs_cyc), 32'd7);
        check("s1_idle_tready", 32'(s_word_tready), 32'd1);
        check("s1_busy", 32'(o_busy), 32'd0);
        check("s1_count", 32'(o_frame_count), 32'd1);

        // 2: dump closed by sentinel.
        @(posedge clk_udp);
        #1 clear_log();
        send_word(32'h0069_000A, 1'b0, 1'b1);
        send_word(32'h005A_8014, 1'b0, 1'b1);
        send_word(32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_idle();
        check("s2_len", 32'(got_q.size()), 32'd15);
        for (int i = 0; i < 15; i++) check("s2_lit", 32'(got_q[i]), 32'(lit2[i]));
        check("s2_count", 32'(o_frame_count), 32'(m_frames));

        // 3: same dump under random backpressure.
        @(posedge clk_udp);
        #1 clear_log();
        bp_en = 1'b1;
        send_word(32'h0069_000A, 1'b0, 1'b1);
        send_word(32'h005A_8014, 1'b0, 1'b1);
        send_word(32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_idle();
        bp_en = 1'b0;
        check("s3_len", 32'(got_q.size()), 32'd15);
        for (int i = 0; i < 15; i++) check("s3_lit", 32'(got_q[i]), 32'(lit2[i]));
        check("s3_count", 32'(o_frame_count), 32'd3);

        // 4: six dump words split at MAX_WORDS = 4.
        @(posedge clk_udp);
        #1 clear_log();
        for (int w = 1; w <= 6; w++) send_word(32'(w), (w == 6), 1'b1);
        wait_idle();
        check("s4_len", 32'(got_q.size()), 32'd30);
        check("s4_split_last", 32'(got_q[18]), 32'h104);
        check("s4_reopen_opc", 32'(got_q[19]), 32'h0F0);
        check("s4_final_last", 32'(got_q[29]), 32'h106);
        check("s4_count", 32'(o_frame_count), 32'd5);

        // 5: source starvation; sentinel value on a trade frame is plain data.
        @(posedge clk_udp);
        #1 clear_log();
        send_word(32'hFFFF_FFFF, 1'b0, 1'b0);
        repeat (20) @(negedge clk_udp);
        check("s5_gap_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("s5_gap_busy", 32'(o_busy), 32'd1);
        check("s5_gap_tready", 32'(s_word_tready), 32'd1);
        check("s5_gap_count", 32'(o_frame_count), 32'd5);
        @(posedge clk_udp);
        #1;
        send_word(32'h1234_5678, 1'b1, 1'b1);
        wait_idle();
        check("s5_len", 32'(got_q.size()), 32'd11);
        check("s5_last", 32'(got_q[10]), 32'h178);
        check("s5_count", 32'(o_frame_count), 32'd6);

        // 6: reset while word byte 2 is on the bus.
        @(posedge clk_udp);
        #1 clear_log();
        send_word(32'h1122_3344, 1'b1, 1'b0);
        begin
            int t = 0;
            forever begin
                @(negedge clk_udp);
                if (m_axis_tvalid && m_axis_tdata == 8'h22) break;
                t++;
                if (t > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL s6_wait: word byte 1 never seen");
                    break;
                end
            end
        end
        @(posedge clk_udp);
        #1 rst_udp = 1'b1;
        model_reset();
        @(negedge clk_udp);
        check("s6_at_wbyte2", 32'(m_axis_tdata), 32'h33);
        check("s6_rst_tready", 32'(s_word_tready), 32'd0);
        @(negedge clk_udp);
        check("s6_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("s6_tlast", 32'(m_axis_tlast), 32'd0);
        check("s6_busy", 32'(o_busy), 32'd0);
        check("s6_count", 32'(o_frame_count), 32'd0);
        @(posedge clk_udp);
        #1 rst_udp = 1'b0;
        clear_log();
        @(negedge clk_udp);
        check("s6_rel_tready", 32'(s_word_tready), 32'd1);
        @(posedge clk_udp);
        #1;
        send_word(32'hCAFE_0001, 1'b1, 1'b1);
        wait_idle();
        check("s6_len", 32'(got_q.size()), 32'd7);
        check("s6_opc0", 32'(got_q[0]), 32'h0F0);
        check("s6_last", 32'(got_q[6]), 32'h101);
        check("s6_count_after", 32'(o_frame_count), 32'd1);

        repeat (3) @(negedge clk_udp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
